loba_split_pipe: RTL and testbench
==================================

// Module: loba_split_pipe
// PURPOSE
// - Parametrised, pipelined successor of the 16-bit/4-bit two-segment LOBA split used by the LOBA multipliers.
// - Splits unsigned operand X into S leading-one-aligned P-bit segments, each with its bit position k.
// - One pipeline stage per segment, with a valid/ready handshake on both sides.
// - Feeds the LOBA partial-product array; W=16,P=4,S=2 gives the existing two-segment split results.
// PARAMETERS
// - W   16  operand width; W >= 2*P required (elaboration $error otherwise)
// - P   4   segment width in bits
// - S   2   number of segments = pipeline stages, S >= 1
// - KW  $clog2(W)  width of each position field (derived localparam, not overridable)
// PORTS
// - clk        in   1      clock, rising edge
// - rst_n      in   1      asynchronous active-low reset
// - in_valid   in   1      in_x is valid this cycle
// - in_ready   out  1      stage 0 can accept; transfer when in_valid && in_ready
// - in_x       in   W      unsigned operand
// - out_valid  out  1      output fields valid
// - out_ready  in   1      downstream accepts; transfer when out_valid && out_ready
// - out_seg    out  S*P    segment s at [s*P +: P], s=0 is most significant
// - out_k      out  S*KW   position of segment s MSB at [s*KW +: KW]
// - out_segv   out  S      bit s = segment s present (bit 0 always 1)
// - out_zero   out  1      operand was zero
// BEHAVIOUR
// - Segment rule, residual R (stage 0: R=in_x), q = index of leading one of R:
// -   stage 0: q>=P-1 -> k=q, seg=R[q-:P]; else (incl. R==0) k=P-1, seg=R[P-1:0]; segv=1.
// -   stage s>0: R!=0 && q>=P-1 -> k=q, seg=R[q-:P], segv=1; else k=0, seg=0, segv=0.
// -   next R = (R!=0 && q>=2P-1) ? R with bits [W-1:q-P+1] cleared : 0 (short tails are dropped).
// - Stage s registers segment s, all earlier segments, next R and zero flag; out_* are stage S-1 regs.
// - Latency S cycles input handshake to out_valid; throughput 1 operand/cycle with out_ready held 1.
// - Elastic: stage s loads when its valid is 0 or stage s+1 accepts (last: out_ready); in_ready = stage-0 load enable.
// - Bubbles collapse: an empty stage accepts even while later stages stall.
// - Stall: while out_valid && !out_ready all out_* hold stable; no operand dropped or duplicated.
// - Simultaneous accept and emit at a full pipeline is legal and must not stall throughput.
// - Reset (any time, incl. mid-flight): all stage valids=0, all data regs=0; out_valid=0, out_seg=0, out_k=0,
//   out_segv=0, out_zero=0; in_ready=1 from first cycle after rst_n rises; in-flight operands discarded.
// - Data regs load only on a stage transfer; invalid stage contents are don't-care for checking except after reset.
// - Leading-one detect is priority logic per stage; no combinational path in_x -> out_*.
// TESTING (W=16,P=4,S=2 unless stated; out_ready=1 unless stated)
// - in_x=16'h1234 -> after 2 cycles: k0=12 seg0=4'h9 segv0=1, k1=5 seg1=4'hD segv1=1, zero=0.
// - in_x=16'h0050 -> k0=6 seg0=4'hA, k1=0 seg1=0 segv1=0; in_x=16'h0005 -> k0=3 seg0=4'h5 segv1=0.
// - in_x=16'h0000 -> k0=3 seg0=0 segv=2'b01 zero=1; in_x=16'h8001 -> k0=15 seg0=4'h8, segv1=0 (tail<P-1 dropped).
// - S=3, in_x=16'hFFFF -> k=(15,11,7), seg=(F,F,F), segv=3'b111; 16'h0880 -> k=(11,7,0), seg=(8,8,0), segv=3'b011.
// - Stream 8 back-to-back operands, out_ready low cycles 3-5: outputs held stable, in_ready=0 once full,
//   all 8 results emitted in order, none lost/duplicated; compare against reference model for random in_x.
// - Assert rst_n low with 2 operands in flight -> out_valid=0, all outputs 0 asynchronously; first new op
//   after release emerges exactly 2 cycles after its accept.

Source files
------------

// File: rtl/loba_split_pipe.sv
// Pipelined leading-one-aligned operand splitter: one elastic stage per P-bit segment.
// Stage s extracts segment s from the residual left by stage s-1 and forwards all earlier fields.
module loba_split_pipe #(
  parameter int W = 16,
  parameter int P = 4,
  parameter int S = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [W-1:0]              in_x,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [S*P-1:0]            out_seg,
  output logic [S*$clog2(W)-1:0]    out_k,
  output logic [S-1:0]              out_segv,
  output logic                      out_zero
);

  localparam int KW = $clog2(W);

  if (W < 2*P) begin : g_bad_width
    $error("loba_split_pipe: W must be at least 2*P");
  end
  if (S < 1) begin : g_bad_stages
    $error("loba_split_pipe: S must be at least 1");
  end

  function automatic logic [KW-1:0] lead_one(input logic [W-1:0] r);
    lead_one = '0;
    for (int i = 0; i < W; i++) begin
      if (r[i]) lead_one = KW'(i);
    end
  endfunction

  logic [S-1:0] vld;
  logic [S-1:0] ld;

  // A stage may load when it or any later stage has a hole, or the output drains.
  always_comb begin
    logic all_full;
    all_full = 1'b1;
    ld = '0;
    for (int s = S-1; s >= 0; s--) begin
      all_full = all_full & vld[s];
      ld[s] = out_ready | ~all_full;
    end
  end

  for (genvar s = 0; s < S; s++) begin : g_st
    logic              v_q;
    logic [S*P-1:0]    seg_q;
    logic [S*KW-1:0]   k_q;
    logic [S-1:0]      segv_q;
    logic              z_q;

    logic              v_in;
    logic [W-1:0]      r_in;
    logic [S*P-1:0]    seg_in;
    logic [S*KW-1:0]   k_in;
    logic [S-1:0]      segv_in;
    logic              z_in;

    logic [S*P-1:0]    seg_d;
    logic [S*KW-1:0]   k_d;
    logic [S-1:0]      segv_d;
    logic [KW-1:0]     q;
    logic [P-1:0]      win;
    logic              hit;

    assign vld[s] = v_q;

    if (s == 0) begin : g_src
      assign v_in    = in_valid;
      assign r_in    = in_x;
      assign seg_in  = '0;
      assign k_in    = '0;
      assign segv_in = '0;
      assign z_in    = ~|in_x;
    end else begin : g_src
      assign v_in    = g_st[s-1].v_q;
      assign r_in    = g_st[s-1].g_res.r_q;
      assign seg_in  = g_st[s-1].seg_q;
      assign k_in    = g_st[s-1].k_q;
      assign segv_in = g_st[s-1].segv_q;
      assign z_in    = g_st[s-1].z_q;
    end

    assign q   = lead_one(r_in);
    assign hit = (|r_in) && (q >= KW'(P-1));
    assign win = P'(r_in >> (q - KW'(P-1)));

    // The first segment is always present; small operands fall back to the low P bits.
    always_comb begin
      seg_d  = seg_in;
      k_d    = k_in;
      segv_d = segv_in;
      if (hit) begin
        seg_d[s*P +: P]   = win;
        k_d[s*KW +: KW]   = q;
        segv_d[s]         = 1'b1;
      end else if (s == 0) begin
        seg_d[s*P +: P]   = r_in[P-1:0];
        k_d[s*KW +: KW]   = KW'(P-1);
        segv_d[s]         = 1'b1;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q    <= 1'b0;
        seg_q  <= '0;
        k_q    <= '0;
        segv_q <= '0;
        z_q    <= 1'b0;
      end else begin
        if (ld[s]) v_q <= v_in;
        if (ld[s] && v_in) begin
          seg_q  <= seg_d;
          k_q    <= k_d;
          segv_q <= segv_d;
          z_q    <= z_in;
        end
      end
    end

    if (s < S-1) begin : g_res
      logic [W-1:0] r_q;
      logic [W-1:0] mask;

      // Tails shorter than a full segment cannot yield another aligned segment, so drop them.
      assign mask = (W'(1) << (q - KW'(P-1))) - W'(1);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_q <= '0;
        end else if (ld[s] && v_in) begin
          r_q <= (hit && (q >= KW'(2*P-1))) ? (r_in & mask) : '0;
        end
      end
    end
  end

  assign in_ready  = ld[0];
  assign out_valid = vld[S-1];
  assign out_seg   = g_st[S-1].seg_q;
  assign out_k     = g_st[S-1].k_q;
  assign out_segv  = g_st[S-1].segv_q;
  assign out_zero  = g_st[S-1].z_q;

endmodule

// File: tb/tb_loba_split_pipe.sv
// Scoreboard bench for loba_split_pipe: S=2 and S=3 instances against an arithmetic reference.
module tb_loba_split_pipe;

  localparam int P = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_x = '0;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_seg;
  logic [7:0]  out_k;
  logic [1:0]  out_segv;
  logic        out_zero;

  logic        in_valid3 = 1'b0;
  logic        in_ready3;
  logic [15:0] in_x3 = '0;
  logic        out_valid3;
  logic        out_ready3 = 1'b1;
  logic [11:0] out_seg3;
  logic [11:0] out_k3;
  logic [2:0]  out_segv3;
  logic        out_zero3;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rand_ready = 1'b0;
  logic ready_hold = 1'b1;

  typedef struct {
    logic [15:0] x;
    logic [7:0]  seg;
    logic [7:0]  k;
    logic [1:0]  segv;
    logic        zero;
    bit          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [15:0] x;
    logic [11:0] seg;
    logic [11:0] k;
    logic [2:0]  segv;
    logic        zero;
  } exp3_t;

  exp_t  sb[$];
  exp3_t sb3[$];

  loba_split_pipe #(.W(16), .P(4), .S(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_seg(out_seg), .out_k(out_k), .out_segv(out_segv), .out_zero(out_zero)
  );

  loba_split_pipe #(.W(16), .P(4), .S(3)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid3), .in_ready(in_ready3), .in_x(in_x3),
    .out_valid(out_valid3), .out_ready(out_ready3),
    .out_seg(out_seg3), .out_k(out_k3), .out_segv(out_segv3), .out_zero(out_zero3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : ready_hold;
    end
  end

  // Reference: peel segments off the operand with plain integer arithmetic.
  function automatic void model(input logic [15:0] x, input int ns,
                                output logic [11:0] seg, output logic [11:0] k,
                                output logic [2:0] segv);
    int r, q, t;
    seg = '0; k = '0; segv = '0;
    r = int'(x);
    for (int s = 0; s < ns; s++) begin
      q = 0; t = r;
      while (t > 1) begin t = t / 2; q++; end
      if (r != 0 && q >= P-1) begin
        seg[s*4 +: 4] = 4'((r >> (q-P+1)) % 16);
        k[s*4 +: 4]   = 4'(q);
        segv[s]       = 1'b1;
      end else if (s == 0) begin
        seg[3:0] = 4'(r % 16);
        k[3:0]   = 4'(P-1);
        segv[0]  = 1'b1;
      end
      r = (r != 0 && q >= 2*P-1) ? r % (1 << (q-P+1)) : 0;
    end
  endfunction

  function automatic exp_t ref2(input logic [15:0] x);
    exp_t e;
    logic [11:0] s, k;
    logic [2:0] v;
    model(x, 2, s, k, v);
    e.x = x; e.seg = s[7:0]; e.k = k[7:0]; e.segv = v[1:0];
    e.zero = (x == 16'h0); e.lat = 1'b0; e.acc = 0;
    return e;
  endfunction

  function automatic exp3_t ref3(input logic [15:0] x);
    exp3_t e;
    model(x, 3, e.seg, e.k, e.segv);
    e.x = x; e.zero = (x == 16'h0);
    return e;
  endfunction

  function automatic exp_t mk2(input logic [15:0] x, input logic [7:0] seg,
                               input logic [7:0] k, input logic [1:0] segv, input logic zero);
    exp_t e;
    e.x = x; e.seg = seg; e.k = k; e.segv = segv; e.zero = zero; e.lat = 1'b0; e.acc = 0;
    return e;
  endfunction

  function automatic exp3_t mk3(input logic [15:0] x, input logic [11:0] seg,
                                input logic [11:0] k, input logic [2:0] segv, input logic zero);
    exp3_t e;
    e.x = x; e.seg = seg; e.k = k; e.segv = segv; e.zero = zero;
    return e;
  endfunction

  task automatic check_out(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic send_op(input exp_t e);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_x = e.x;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      total++; bad++;
      $display("[TB] FAIL accept_timeout x=%h: got in_ready=0 want 1", e.x);
    end else begin
      e.acc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_op3(input exp3_t e);
    int n;
    n = 0;
    in_valid3 = 1'b1;
    in_x3 = e.x;
    @(negedge clk);
    while (!in_ready3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready3) begin
      total++; bad++;
      $display("[TB] FAIL accept3_timeout x=%h: got in_ready=0 want 1", e.x);
    end else begin
      sb3.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid3 = 1'b0;
  endtask

  task automatic wait_drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || sb3.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0 || sb3.size() != 0) begin
      total++; bad++;
      $display("[TB] FAIL drain_timeout: got pending=%0d/%0d want 0/0", sb.size(), sb3.size());
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor for S=2: head of queue must be on the outputs whenever out_valid, stalled or not.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (sb.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_out: got seg=%h k=%h want no output", out_seg, out_k);
      end else begin
        e = sb[0];
        total++;
        if ({out_seg, out_k, out_segv, out_zero} !== {e.seg, e.k, e.segv, e.zero}) begin
          bad++;
          $display("[TB] FAIL out x=%h: got seg=%h k=%h segv=%b zero=%b want seg=%h k=%h segv=%b zero=%b",
                   e.x, out_seg, out_k, out_segv, out_zero, e.seg, e.k, e.segv, e.zero);
        end
        if (out_ready) begin
          void'(sb.pop_front());
          if (e.lat) begin
            total++;
            if (cyc - e.acc != 2) begin
              bad++;
              $display("[TB] FAIL latency x=%h: got %0d want 2", e.x, cyc - e.acc);
            end
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    exp3_t e;
    if (rst_n && out_valid3) begin
      if (sb3.size() == 0) begin
        total++; bad++;
        $display("[TB] FAIL unexpected_out3: got seg=%h k=%h want no output", out_seg3, out_k3);
      end else begin
        e = sb3.pop_front();
        total++;
        if ({out_seg3, out_k3, out_segv3, out_zero3} !== {e.seg, e.k, e.segv, e.zero}) begin
          bad++;
          $display("[TB] FAIL out3 x=%h: got seg=%h k=%h segv=%b zero=%b want seg=%h k=%h segv=%b zero=%b",
                   e.x, out_seg3, out_k3, out_segv3, out_zero3, e.seg, e.k, e.segv, e.zero);
        end
      end
    end
  end

  initial begin
    exp_t dir[5];
    logic [15:0] sx[8];
    exp_t e;
    int c, i, gap;

    #1;
    check_out("rst_out_valid", 32'(out_valid), 32'h0);
    check_out("rst_out_seg",   32'(out_seg),   32'h0);
    check_out("rst_out_k",     32'(out_k),     32'h0);
    check_out("rst_out_segv",  32'(out_segv),  32'h0);
    check_out("rst_out_zero",  32'(out_zero),  32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("ready_after_rst", 32'(in_ready), 32'h1);

    dir[0] = mk2(16'h1234, 8'hD9, 8'h5C, 2'b11, 1'b0);
    dir[1] = mk2(16'h0050, 8'h0A, 8'h06, 2'b01, 1'b0);
    dir[2] = mk2(16'h0005, 8'h05, 8'h03, 2'b01, 1'b0);
    dir[3] = mk2(16'h0000, 8'h00, 8'h03, 2'b01, 1'b1);
    dir[4] = mk2(16'h8001, 8'h08, 8'h0F, 2'b01, 1'b0);
    foreach (dir[j]) send_op(dir[j]);
    send_op3(mk3(16'hFFFF, 12'hFFF, 12'h7BF, 3'b111, 1'b0));
    send_op3(mk3(16'h0880, 12'h088, 12'h07B, 3'b011, 1'b0));
    wait_drain();

    // Back-to-back burst with a three-cycle downstream stall.
    foreach (sx[j]) sx[j] = 16'($urandom);
    c = 0; i = 0;
    while (i < 8 && c < 100) begin
      ready_hold = !(c >= 3 && c <= 5);
      in_valid = 1'b1;
      in_x = sx[i];
      @(negedge clk);
      if (c == 4 || c == 5) check_out("full_in_ready", 32'(in_ready), 32'h0);
      if (in_ready) begin
        sb.push_back(ref2(sx[i]));
        i++;
      end
      @(posedge clk);
      #1;
      c++;
    end
    in_valid = 1'b0;
    ready_hold = 1'b1;
    wait_drain();

    rand_ready = 1'b1;
    for (int n = 0; n < 60; n++) begin
      send_op(ref2(16'($urandom) >> $urandom_range(0, 15)));
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
    end
    for (int n = 0; n < 16; n++) send_op3(ref3(16'($urandom) >> $urandom_range(0, 15)));
    rand_ready = 1'b0;
    wait_drain();

    // Reset with two operands in flight, then time a fresh operand.
    send_op(ref2(16'h4321));
    send_op(ref2(16'h0F0F));
    #2;
    rst_n = 1'b0;
    #1;
    check_out("midrst_out_valid", 32'(out_valid), 32'h0);
    check_out("midrst_out_seg",   32'(out_seg),   32'h0);
    check_out("midrst_out_k",     32'(out_k),     32'h0);
    check_out("midrst_out_segv",  32'(out_segv),  32'h0);
    check_out("midrst_out_zero",  32'(out_zero),  32'h0);
    sb.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_out("ready_after_midrst", 32'(in_ready), 32'h1);
    e = ref2(16'h2468);
    e.lat = 1'b1;
    send_op(e);
    wait_drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
